// File: rtl/pwm_timebase_if.sv
// Processor bus port of the PWM timebase: write strobe, register select,
// write data and the combinational readback.
interface pwm_timebase_if #(
    parameter int WIDTH = 8
) ();
    logic             we;
    logic [1:0]       addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;

    modport master (
        output we,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  we,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaled running count plus duty threshold for the PWM
// comparator. Prescale, period and duty are shadow-buffered and only
// transferred to the active copies at a period boundary (or continuously
// while disabled), so the comparator never sees a mid-period change.
module pwm_timebase #(
    parameter int WIDTH    = 8,
    parameter int PS_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    pwm_timebase_if.slave    bus,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] duty,
    output logic             period_tick,
    output logic             running
);

    localparam logic [1:0]          ADDR_CTRL     = 2'd0;
    localparam logic [1:0]          ADDR_PRESCALE = 2'd1;
    localparam logic [1:0]          ADDR_PERIOD   = 2'd2;
    localparam logic [1:0]          ADDR_DUTY     = 2'd3;
    localparam logic [WIDTH-1:0]    CNT_ZERO      = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]    CNT_ONES      = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]    CNT_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PS_WIDTH-1:0] PS_ZERO       = {PS_WIDTH{1'b0}};
    localparam logic [PS_WIDTH-1:0] PS_ONE        = {{(PS_WIDTH-1){1'b0}}, 1'b1};

    logic                enable_r;
    logic [PS_WIDTH-1:0] prescale_sh_r;
    logic [WIDTH-1:0]    period_sh_r;
    logic [WIDTH-1:0]    duty_sh_r;
    logic [PS_WIDTH-1:0] prescale_act_r;
    logic [WIDTH-1:0]    period_act_r;
    logic [WIDTH-1:0]    duty_act_r;
    logic [PS_WIDTH-1:0] pre_cnt_r;
    logic [WIDTH-1:0]    count_r;
    logic                tick_r;
    logic                step_s;
    logic                wrap_s;
    logic [WIDTH-1:0]    rdata_s;

    // Prescaler terminal value reached: the count advances on this edge
    always_comb begin
        step_s = 1'b0;
        if (enable_r && (pre_cnt_r == prescale_act_r)) begin
            step_s = 1'b1;
        end else begin
            step_s = 1'b0;
        end
    end

    // Period boundary: a step while the count sits on the active period
    always_comb begin
        wrap_s = 1'b0;
        if (step_s && (count_r == period_act_r)) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
    end

    // Readback returns the shadow (programmed) values, not the active ones
    always_comb begin
        rdata_s = CNT_ZERO;
        case (bus.addr)
            ADDR_CTRL:     rdata_s = {{(WIDTH-1){1'b0}}, enable_r};
            ADDR_PRESCALE: rdata_s = WIDTH'(prescale_sh_r);
            ADDR_PERIOD:   rdata_s = period_sh_r;
            ADDR_DUTY:     rdata_s = duty_sh_r;
            default:       rdata_s = CNT_ZERO;
        endcase
    end

    // Bus writes land in the enable bit and the shadow registers only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_r      <= 1'b0;
            prescale_sh_r <= PS_ZERO;
            period_sh_r   <= CNT_ONES;
            duty_sh_r     <= CNT_ZERO;
        end else if (bus.we) begin
            case (bus.addr)
                ADDR_CTRL:     enable_r      <= bus.wdata[0];
                ADDR_PRESCALE: prescale_sh_r <= PS_WIDTH'(bus.wdata);
                ADDR_PERIOD:   period_sh_r   <= bus.wdata;
                ADDR_DUTY:     duty_sh_r     <= bus.wdata;
                default:       enable_r      <= enable_r;
            endcase
        end
    end

    // Active copies track the shadows while idle and reload at each wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_act_r <= PS_ZERO;
            period_act_r   <= CNT_ONES;
            duty_act_r     <= CNT_ZERO;
        end else if (!enable_r || wrap_s) begin
            prescale_act_r <= prescale_sh_r;
            period_act_r   <= period_sh_r;
            duty_act_r     <= duty_sh_r;
        end
    end

    // Prescale counter: restarts on each step, held at zero while disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt_r <= PS_ZERO;
        end else if (!enable_r || step_s) begin
            pre_cnt_r <= PS_ZERO;
        end else begin
            pre_cnt_r <= pre_cnt_r + PS_ONE;
        end
    end

    // Running count and the one-cycle wrap pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= CNT_ZERO;
            tick_r  <= 1'b0;
        end else if (!enable_r) begin
            count_r <= CNT_ZERO;
            tick_r  <= 1'b0;
        end else if (wrap_s) begin
            count_r <= CNT_ZERO;
            tick_r  <= 1'b1;
        end else if (step_s) begin
            count_r <= count_r + CNT_ONE;
            tick_r  <= 1'b0;
        end else begin
            tick_r  <= 1'b0;
        end
    end

    assign count       = count_r;
    assign duty        = duty_act_r;
    assign period_tick = tick_r;
    assign running     = enable_r;
    assign bus.rdata   = rdata_s;

endmodule

// File: tb/tb_pwm_timebase.sv
// Scoreboard bench for pwm_timebase. The driver advances a reference model
// that tracks elapsed cycles within a period and derives the count from it
// arithmetically; expected outputs are queued and a negedge monitor compares.
module tb_pwm_timebase;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] count;
    logic [W-1:0] duty;
    logic         period_tick;
    logic         running;

    pwm_timebase_if #(.WIDTH(W)) bus ();

    pwm_timebase #(.WIDTH(W), .PS_WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .count       (count),
        .duty        (duty),
        .period_tick (period_tick),
        .running     (running)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] cnt;
        logic [7:0] dty;
        logic       tick;
        logic       run;
        logic [7:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    bit   started = 1'b0;
    bit   rst_nxt = 1'b1;

    // Reference model: enable, cycles elapsed in current period, active and shadow values
    bit m_en;
    bit m_tick;
    int m_t;
    int m_ps, m_per, m_duty;
    int s_ps, s_per, s_duty;

    function automatic void model_reset();
        m_en = 1'b0; m_tick = 1'b0; m_t = 0;
        m_ps = 0; m_per = 255; m_duty = 0;
        s_ps = 0; s_per = 255; s_duty = 0;
    endfunction

    function automatic int plen();
        return (m_per + 1) * (m_ps + 1);
    endfunction

    function automatic int model_count();
        return m_t / (m_ps + 1);
    endfunction

    // One rising edge: counter first using pre-edge state, then bus write
    function automatic void model_edge();
        if (reset) begin
            model_reset();
            return;
        end
        if (!m_en) begin
            m_t = 0; m_tick = 1'b0;
            m_ps = s_ps; m_per = s_per; m_duty = s_duty;
        end else begin
            m_t = m_t + 1;
            if (m_t == plen()) begin
                m_t = 0; m_tick = 1'b1;
                m_ps = s_ps; m_per = s_per; m_duty = s_duty;
            end else begin
                m_tick = 1'b0;
            end
        end
        if (bus.we) begin
            case (bus.addr)
                2'd0: m_en   = bus.wdata[0];
                2'd1: s_ps   = int'(bus.wdata);
                2'd2: s_per  = int'(bus.wdata);
                default: s_duty = int'(bus.wdata);
            endcase
        end
    endfunction

    function automatic void push_expected();
        exp_t e;
        e.cnt  = 8'(model_count());
        e.dty  = 8'(m_duty);
        e.tick = m_tick;
        e.run  = m_en;
        case (bus.addr)
            2'd0: e.rd = {7'd0, m_en};
            2'd1: e.rd = 8'(s_ps);
            2'd2: e.rd = 8'(s_per);
            default: e.rd = 8'(s_duty);
        endcase
        exp_q.push_back(e);
        started = 1'b1;
    endfunction

    // One clock: model the edge, then present the next bus cycle
    task automatic cyc(input bit w, input int a, input int d);
        @(posedge clk);
        model_edge();
        #2;
        bus.we    = w;
        bus.addr  = a[1:0];
        bus.wdata = d[7:0];
        reset     = rst_nxt;
        if (reset) model_reset();
        push_expected();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
    endtask

    task automatic wait_count(input int v, input int maxc);
        int k;
        k = 0;
        while (!(m_en && model_count() == v) && k < maxc) begin
            idle(1);
            k++;
        end
        if (k >= maxc) begin
            checks++; errors++;
            $display("FAIL wait_count: model never reached count %0d within %0d cycles", v, maxc);
        end
    endtask

    task automatic wait_wrap_next(input int maxc);
        int k;
        k = 0;
        while (!(m_en && m_t == plen() - 1) && k < maxc) begin
            idle(1);
            k++;
        end
        if (k >= maxc) begin
            checks++; errors++;
            $display("FAIL wait_wrap: no wrap within %0d cycles", maxc);
        end
    endtask

    function automatic void chk(string nm, logic [7:0] act, logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endfunction

    // Monitor: every negedge compares DUT outputs against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                if (started) begin
                    checks++; errors++;
                    $display("FAIL scoreboard: no expectation queued at %0t", $time);
                end
            end else begin
                e = exp_q.pop_front();
                chk("count", count, e.cnt);
                chk("duty", duty, e.dty);
                chk("period_tick", {7'd0, period_tick}, {7'd0, e.tick});
                chk("running", {7'd0, running}, {7'd0, e.run});
                chk("rdata", bus.rdata, e.rd);
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized bus traffic
    initial begin
        int a;
        int d;
        reset     = 1'b1;
        bus.we    = 1'b0;
        bus.addr  = 2'd2;
        bus.wdata = 8'd0;
        model_reset();

        cyc(1'b0, 2, 0);
        cyc(1'b0, 2, 0);
        rst_nxt = 1'b0;
        cyc(1'b0, 2, 0);

        // basic counting, period 4, no prescale
        cyc(1'b1, 2, 4); cyc(1'b1, 1, 0); cyc(1'b1, 3, 2); cyc(1'b1, 0, 1);
        idle(15);

        // prescale 2, period 3
        cyc(1'b1, 0, 0); cyc(1'b1, 1, 2); cyc(1'b1, 2, 3); cyc(1'b1, 0, 1);
        idle(30);

        // asynchronous reset mid-count
        wait_count(2, 20);
        rst_nxt = 1'b1;
        cyc(1'b0, 2, 0); cyc(1'b0, 2, 0);
        rst_nxt = 1'b0;
        cyc(1'b0, 2, 0);

        // duty shadow write mid-period
        cyc(1'b1, 2, 9); cyc(1'b1, 1, 0); cyc(1'b1, 3, 1); cyc(1'b1, 0, 1);
        wait_count(3, 40);
        cyc(1'b1, 3, 7); cyc(1'b0, 3, 0);
        idle(15);

        // period write colliding with the wrap edge
        cyc(1'b1, 2, 5);
        wait_wrap_next(60);
        idle(1);
        wait_wrap_next(60);
        cyc(1'b1, 2, 2);
        idle(20);

        // period 0: tick on every step
        cyc(1'b1, 2, 0);
        idle(12);

        // disable mid-period and re-enable with prescale 1
        cyc(1'b1, 2, 9); cyc(1'b1, 1, 1);
        wait_wrap_next(40);
        idle(1);
        wait_count(3, 40);
        cyc(1'b1, 0, 0);
        idle(3);
        cyc(1'b1, 0, 1);
        idle(10);

        // duty above period is passed through unclamped
        cyc(1'b1, 3, 200);
        idle(50);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = int'($urandom_range(0, 3));
                case (a)
                    0: d = ($urandom_range(0, 7) != 0) ? 1 : 0;
                    1: d = int'($urandom_range(0, 3));
                    2: d = int'($urandom_range(0, 12));
                    default: d = int'($urandom_range(0, 255));
                endcase
                cyc(1'b1, a, d);
            end else begin
                idle(1);
            end
        end

        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
